// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: column/row counters with registered,
// mutually aligned sync, active-video, line/frame strobes and coordinates.
module vga_timing_gen #(
  parameter int ACTIVE_COLS   = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int ACTIVE_ROWS   = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int COUNT_WIDTH   = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Pix_En,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic [COUNT_WIDTH-1:0] o_Col_Count,
  output logic [COUNT_WIDTH-1:0] o_Row_Count,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start
);

  localparam int H_TOTAL        = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL        = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int H_SYNC_START   = ACTIVE_COLS + H_FRONT_PORCH;
  localparam int H_SYNC_END     = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START   = ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int V_SYNC_END     = V_SYNC_START + V_SYNC;
  localparam longint COUNT_SPAN = longint'(1) << COUNT_WIDTH;

  localparam logic [COUNT_WIDTH-1:0] H_LAST = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST = COUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  // Reject configurations the counters or sync logic cannot represent.
  if (H_SYNC < 1) begin : g_bad_h_sync
    $error("vga_timing_gen: H_SYNC must be at least 1");
  end
  if (V_SYNC < 1) begin : g_bad_v_sync
    $error("vga_timing_gen: V_SYNC must be at least 1");
  end
  if (COUNT_SPAN < longint'(H_TOTAL) || COUNT_SPAN < longint'(V_TOTAL)) begin : g_bad_width
    $error("vga_timing_gen: COUNT_WIDTH too small for H_TOTAL/V_TOTAL");
  end

  logic [COUNT_WIDTH-1:0] col_q, col_d;
  logic [COUNT_WIDTH-1:0] row_q, row_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   active_q, active_d;
  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;

  // All outputs are derived from the next position so they stay aligned with the counts.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (i_Pix_En) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        if (row_q == V_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + ONE;
        end
      end else begin
        col_d = col_q + ONE;
      end

      hsync_d = ((int'(col_d) >= H_SYNC_START) && (int'(col_d) < H_SYNC_END))
                ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = ((int'(row_d) >= V_SYNC_START) && (int'(row_d) < V_SYNC_END))
                ? VSYNC_POL : ~VSYNC_POL;
      active_d      = (int'(col_d) < ACTIVE_COLS) && (int'(row_d) < ACTIVE_ROWS);
      line_start_d  = (col_d == '0);
      frame_start_d = (col_d == '0) && (row_d == '0);
    end
  end

  // Reset parks the raster on the last back-porch pixel so the first advance lands on (0,0).
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_q         <= H_LAST;
      row_q         <= V_LAST;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 12x7 raster, with an active-low and an
// active-high sync instance driven by the same stimulus.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b1;

  logic       hs_lo, vs_lo, act_lo, ls_lo, fs_lo;
  logic [3:0] col_lo, row_lo;
  logic       hs_hi, vs_hi, act_hi, ls_hi, fs_hi;
  logic [3:0] col_hi, row_hi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .ACTIVE_COLS(8), .H_FRONT_PORCH(1), .H_SYNC(2), .H_BACK_PORCH(1),
    .ACTIVE_ROWS(4), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COUNT_WIDTH(4)
  ) dut_lo (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(pix_en),
    .o_HSync(hs_lo), .o_VSync(vs_lo), .o_Active(act_lo),
    .o_Col_Count(col_lo), .o_Row_Count(row_lo),
    .o_Line_Start(ls_lo), .o_Frame_Start(fs_lo)
  );

  vga_timing_gen #(
    .ACTIVE_COLS(8), .H_FRONT_PORCH(1), .H_SYNC(2), .H_BACK_PORCH(1),
    .ACTIVE_ROWS(4), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COUNT_WIDTH(4)
  ) dut_hi (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(pix_en),
    .o_HSync(hs_hi), .o_VSync(vs_hi), .o_Active(act_hi),
    .o_Col_Count(col_hi), .o_Row_Count(row_hi),
    .o_Line_Start(ls_hi), .o_Frame_Start(fs_hi)
  );

  typedef struct {
    logic rst;
    logic en;
    int   col;
    int   row;
    logic hs;
    logic vs;
    logic act;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, int c, int w, logic h, logic v,
                              logic a, logic l, logic f);
    vec_t t;
    t.rst = r; t.en = e; t.col = c; t.row = w;
    t.hs = h; t.vs = v; t.act = a; t.ls = l; t.fs = f;
    return t;
  endfunction

  // Inputs change 2ns after the active edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic r, input logic e);
    rst = r;
    pix_en = e;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetAndStart();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  int hs_low, hs_wrong, vs_low, vs_wrong, act_cnt, act_wrong, ls_cnt, fs_cnt;
  int pos_wrong, pol_wrong, hs_low_line, found_at;

  initial begin
    // Reset, first advance, stall, then the tail of line 0 into line 1.
    vecs.push_back(mk(1, 1, 11, 6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 11, 6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 0));
    for (int c = 2; c <= 7; c++) vecs.push_back(mk(0, 1, c, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 10, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 11, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en);
      checkOutput($sformatf("v%0d_col", i), int'(col_lo), vecs[i].col);
      checkOutput($sformatf("v%0d_row", i), int'(row_lo), vecs[i].row);
      checkOutput($sformatf("v%0d_hsync", i), int'(hs_lo), int'(vecs[i].hs));
      checkOutput($sformatf("v%0d_vsync", i), int'(vs_lo), int'(vecs[i].vs));
      checkOutput($sformatf("v%0d_active", i), int'(act_lo), int'(vecs[i].act));
      checkOutput($sformatf("v%0d_line_start", i), int'(ls_lo), int'(vecs[i].ls));
      checkOutput($sformatf("v%0d_frame_start", i), int'(fs_lo), int'(vecs[i].fs));
      checkOutput($sformatf("v%0d_hsync_pol1", i), int'(hs_hi), int'(!vecs[i].hs));
      checkOutput($sformatf("v%0d_vsync_pol1", i), int'(vs_hi), int'(!vecs[i].vs));
    end

    // One free-running frame starting from the observed (0,0).
    resetAndStart();
    hs_low = 0; hs_wrong = 0; vs_low = 0; vs_wrong = 0; act_cnt = 0; act_wrong = 0;
    ls_cnt = 0; fs_cnt = 0; pos_wrong = 0; pol_wrong = 0;
    for (int k = 0; k < 84; k++) begin
      automatic int ec = k % 12;
      automatic int er = k / 12;
      automatic logic exp_hs_on = (ec >= 9) && (ec <= 10);
      automatic logic exp_vs_on = (er == 5);
      automatic logic exp_act = (ec < 8) && (er < 4);
      if (int'(col_lo) != ec || int'(row_lo) != er) pos_wrong++;
      if (!hs_lo) hs_low++;
      if (!hs_lo != exp_hs_on) hs_wrong++;
      if (!vs_lo) vs_low++;
      if (!vs_lo != exp_vs_on) vs_wrong++;
      if (act_lo) act_cnt++;
      if (act_lo != exp_act) act_wrong++;
      if (hs_hi != exp_hs_on || vs_hi != exp_vs_on || act_hi != exp_act) pol_wrong++;
      if (ls_lo) ls_cnt++;
      if (fs_lo && k != 0) fs_cnt++;
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("frame_positions", pos_wrong, 0);
    checkOutput("frame_hsync_low_clocks", hs_low, 14);
    checkOutput("frame_hsync_placement", hs_wrong, 0);
    checkOutput("frame_vsync_low_clocks", vs_low, 12);
    checkOutput("frame_vsync_placement", vs_wrong, 0);
    checkOutput("frame_active_clocks", act_cnt, 32);
    checkOutput("frame_active_placement", act_wrong, 0);
    checkOutput("frame_pol1_levels", pol_wrong, 0);
    checkOutput("frame_line_starts", ls_cnt, 7);
    checkOutput("frame_early_frame_start", fs_cnt, 0);
    checkOutput("frame_period_84_fs", int'(fs_lo), 1);
    checkOutput("frame_period_84_col", int'(col_lo), 0);
    checkOutput("frame_period_84_row", int'(row_lo), 0);

    // Alternating pixel enable doubles every duration.
    resetAndStart();
    checkOutput("alt_start_fs", int'(fs_lo), 1);
    found_at = -1; hs_low = 0; hs_low_line = 0; ls_cnt = 0;
    for (int n = 1; n <= 400; n++) begin
      applyStimulus(1'b0, (n % 2) == 0);
      if (!hs_lo) begin
        hs_low++;
        if (n <= 24) hs_low_line++;
      end
      if (ls_lo) ls_cnt++;
      if (fs_lo) begin
        found_at = n;
        break;
      end
    end
    checkOutput("alt_frame_period", found_at, 168);
    checkOutput("alt_hsync_low_first_line", hs_low_line, 4);
    checkOutput("alt_hsync_low_frame", hs_low, 28);
    checkOutput("alt_line_starts", ls_cnt, 7);
    applyStimulus(1'b0, 1'b0);
    checkOutput("alt_fs_width", int'(fs_lo), 0);
    checkOutput("alt_stall_col", int'(col_lo), 0);

    // Reset asserted mid-frame at (5,2).
    resetAndStart();
    for (int k = 0; k < 29; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("mid_pre_col", int'(col_lo), 5);
    checkOutput("mid_pre_row", int'(row_lo), 2);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rst_col", int'(col_lo), 11);
    checkOutput("mid_rst_row", int'(row_lo), 6);
    checkOutput("mid_rst_hsync", int'(hs_lo), 1);
    checkOutput("mid_rst_vsync", int'(vs_lo), 1);
    checkOutput("mid_rst_active", int'(act_lo), 0);
    checkOutput("mid_rst_ls", int'(ls_lo), 0);
    checkOutput("mid_rst_fs", int'(fs_lo), 0);
    checkOutput("mid_rst_hsync_pol1", int'(hs_hi), 0);
    checkOutput("mid_rst_vsync_pol1", int'(vs_hi), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mid_rel_col", int'(col_lo), 0);
    checkOutput("mid_rel_row", int'(row_lo), 0);
    checkOutput("mid_rel_ls", int'(ls_lo), 1);
    checkOutput("mid_rel_fs", int'(fs_lo), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed sync-pulse block. It has independent front porch, sync and back porch lengths per axis, selectable sync polarity, and a pixel clock-enable. It also drives active-video, line-start and frame-start strobes plus active-area coordinates. It sits at the head of the video pipeline and feeds the pattern generator, porch stage and framebuffer reader.

## Interface
- ACTIVE_COLS, 640: visible pixels per line
- H_FRONT_PORCH, 16: pixels between active video and HSync
- H_SYNC, 96: HSync width in pixels (≥1)
- H_BACK_PORCH, 48: pixels between HSync and the next line
- ACTIVE_ROWS, 480: visible lines per frame
- V_FRONT_PORCH, 10: lines between active video and VSync
- V_SYNC, 2: VSync width in lines (≥1)
- V_BACK_PORCH, 33: lines between VSync and the next frame
- HSYNC_POL, 0: asserted level of o_HSync (0 = active-low)
- VSYNC_POL, 0: asserted level of o_VSync
- COUNT_WIDTH, 10: counter width; must satisfy 2^COUNT_WIDTH ≥ max(H_TOTAL, V_TOTAL), otherwise elaboration error
- Derived values:
  - H_TOTAL = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH
  - V_TOTAL is the same sum over the vertical parameters.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Pix_En  in  1  pixel enable; the raster advances only on edges where it is high
- o_HSync  out  1  horizontal sync, polarity set by HSYNC_POL
- o_VSync  out  1  vertical sync, polarity set by VSYNC_POL
- o_Active  out  1  high while the current position is in the visible area
- o_Col_Count  out  COUNT_WIDTH  current column, 0..H_TOTAL-1
- o_Row_Count  out  COUNT_WIDTH  current row, 0..V_TOTAL-1
- o_Line_Start  out  1  one-clock pulse when the column becomes 0
- o_Frame_Start  out  1  one-clock pulse when (col,row) becomes (0,0)

## Operation
- Line layout: columns 0..ACTIVE_COLS-1 are active, then front porch, then sync, then back porch. Rows use the same ordering.
- Advance, on each edge with i_Pix_En=1:
  - col increments.
  - When col = H_TOTAL-1, col wraps to 0 and row increments.
  - When row = V_TOTAL-1 and col wraps, row also wraps to 0.
- o_HSync is asserted iff ACTIVE_COLS+H_FRONT_PORCH ≤ col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC. Deasserted level is ~HSYNC_POL.
- o_VSync is asserted iff ACTIVE_ROWS+V_FRONT_PORCH ≤ row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC. It changes only together with a row change, i.e. at col 0.
- o_Active = (col < ACTIVE_COLS) && (row < ACTIVE_ROWS).
- o_Line_Start and o_Frame_Start assert only in the clock that follows an enabled advance into col 0 (line) or into (0,0) (frame).
- Stall: with i_Pix_En=0, every level output and count holds, and both strobes are 0.
- Reset values:
  - o_Col_Count = H_TOTAL-1 and o_Row_Count = V_TOTAL-1 (the last back-porch pixel).
  - o_Active = 0, o_Line_Start = 0, o_Frame_Start = 0.
  - o_HSync = ~HSYNC_POL and o_VSync = ~VSYNC_POL.
- Reset overrides i_Pix_En. The first enabled edge after reset produces (0,0) with both strobes high.

## Timing
- All outputs are registered and mutually aligned. In the cycle after an enabled edge, every output reflects the new (col,row); there is no skew between sync, active, strobes and counts.
- Zero combinational paths from inputs to outputs.
- Reset asserted mid-frame takes effect at the next edge: the following cycle shows the reset values.
- Frame period is H_TOTAL × V_TOTAL enabled cycles.
- A porch parameter of 0 is legal. Sync widths of 0 are an elaboration error.

## Test plan
Bench parameters: ACTIVE_COLS=8, H_FRONT_PORCH=1, H_SYNC=2, H_BACK_PORCH=1 (H_TOTAL=12); ACTIVE_ROWS=4, V_FRONT_PORCH=1, V_SYNC=1, V_BACK_PORCH=1 (V_TOTAL=7); COUNT_WIDTH=4; i_Pix_En=1 unless stated.
- Release reset, one edge -> counts (0,0), o_Active=1, o_Line_Start=o_Frame_Start=1. Next o_Frame_Start follows exactly 84 clocks later.
- Free-run one frame -> o_HSync low exactly at cols 9–10 of every row (2 clocks, period 12). o_Line_Start pulses 7 times per frame.
- Free-run one frame -> o_VSync low for 12 clocks, from (0,5) through (11,5). o_Active high for exactly 32 clocks: cols 0–7 of rows 0–3.
- i_Pix_En alternating 1/0 -> o_Frame_Start period 168 clocks, each pulse 1 clock wide; o_HSync low for 4 clocks.
- HSYNC_POL=1, VSYNC_POL=1 -> idle level 0; o_HSync high at cols 9–10; o_VSync high on row 5.
- Assert i_Reset at (5,2) with i_Pix_En=1 -> next cycle shows counts (11,6) and all reset values. Deassert reset -> (0,0) with both strobes high.
